esm_evict_scheduler: RTL and testbench

- Sequences the ESM buffer slot pool: allocates free slots to writers and picks a uniformly random occupied slot for eviction/readout.
- Builds a compacted candidate map of occupied slots over BS cycles, then indexes it with `LFSR mod count`.
- Sits between the buffer write path, the readout consumer and the slot storage array.

---
 rtl/esm_pkg.sv | 29 ++
 rtl/esm_lfsr.sv | 19 +
 rtl/esm_evict_scheduler.sv | 142 ++++++++++++++
 tb/tb_esm_evict_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared constants, FSM state type and the free-slot priority encoder for the
// ESM eviction scheduler.
package esm_pkg;

   localparam int          BS_DEF     = 16;
   localparam int          LFSR_W_DEF = 32;
   localparam int          BS_MAX     = 256;
   // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
   localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
   localparam logic [31:0] SEED_DEF   = 32'hACE1_0001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PICK    = 2'd2,
      PRESENT = 2'd3
   } state_t;

   // Index of the lowest clear bit; 0 when every bit is set.
   function automatic int unsigned lowest_zero(input logic [BS_MAX-1:0] v);
      int unsigned r;
      r = 0;
      for (int i = BS_MAX - 1; i >= 0; i--) begin
         if (!v[i]) r = unsigned'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/esm_lfsr.sv
// Free-running Galois LFSR; held at SEED while reset is asserted.
module esm_lfsr
   import esm_pkg::*;
#(
   parameter int           W    = LFSR_W_DEF,
   parameter logic [W-1:0] SEED = W'(SEED_DEF),
   parameter logic [W-1:0] POLY = W'(LFSR_POLY)
) (
   input  logic         clk,
   input  logic         rst,
   output logic [W-1:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) value <= SEED;
      else     value <= {1'b0, value[W-1:1]} ^ (value[0] ? POLY : '0);
   end

endmodule

// File: rtl/esm_evict_scheduler.sv
// Slot pool sequencer: lowest-free allocation for writers and uniformly random
// eviction of an occupied slot. ESM_FIXED_PRIO_EN forces lowest-index picks.
module esm_evict_scheduler
   import esm_pkg::*;
#(
   parameter int                BS     = BS_DEF,
   parameter int                LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   output logic                  wr_gnt,
   output logic [$clog2(BS)-1:0] wr_idx,
   input  logic                  rd_req,
   output logic                  rd_valid,
   output logic [$clog2(BS)-1:0] rd_idx,
   input  logic                  rd_ack,
   output logic [BS-1:0]         occ,
   output logic                  full,
   output logic                  empty,
   output logic                  busy,
   output state_t                state
);

   localparam int IW = $clog2(BS);

   // rd_valid/rd_idx form a hold-until-ack handshake: once rd_valid rises the
   // slot index is stable until the cycle rd_ack is sampled high.

   state_t              state_next;
   logic [LFSR_W-1:0]   lfsr;
   logic [BS-1:0]       cand;
   logic [IW:0]         cand_count;
   logic [IW:0]         scan_idx;
   logic [IW-1:0]       map [BS];
   logic [IW-1:0]       sel_q;
   logic [IW-1:0]       sel_calc;
   logic [BS-1:0]       occ_next;
   logic [BS_MAX-1:0]   padded;
   logic                scan_last;
   logic                accept, scan_step, sel_load, pick_load, release_slot;

   esm_lfsr #(.W(LFSR_W), .SEED(SEED), .POLY(LFSR_W'(LFSR_POLY))) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr)
   );

   assign full  = &occ;
   assign empty = ~|occ;

   always_comb begin
      padded         = '1;
      padded[BS-1:0] = occ;
   end

   assign wr_gnt = wr_req & ~full;
   assign wr_idx = full ? '0 : IW'(lowest_zero(padded));

   // One extra SCAN cycle after the last slot lets cand_count settle before
   // the modulo result is registered for PICK.
   assign scan_last = (scan_idx == (IW+1)'(BS));

`ifdef ESM_FIXED_PRIO_EN
   assign sel_calc = '0;
`else
   logic [LFSR_W-1:0] mod_wide;
   assign mod_wide = lfsr % LFSR_W'(cand_count);
   assign sel_calc = mod_wide[IW-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rd_req && !empty) state_next = SCAN;
         SCAN:    if (scan_last)        state_next = PICK;
         PICK:                          state_next = PRESENT;
         PRESENT: if (rd_ack)           state_next = IDLE;
         default:                       state_next = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      accept       = (state == IDLE) && rd_req && !empty;
      scan_step    = (state == SCAN) && !scan_last;
      sel_load     = (state == SCAN) && scan_last;
      pick_load    = (state == PICK);
      release_slot = (state == PRESENT) && rd_ack;
   end

   // Allocation uses pre-update occ, so a slot freed this cycle is not re-granted.
   always_comb begin
      occ_next = occ;
      if (wr_gnt)       occ_next[wr_idx] = 1'b1;
      if (release_slot) occ_next[rd_idx] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ        <= '0;
         cand       <= '0;
         cand_count <= '0;
         scan_idx   <= '0;
         sel_q      <= '0;
         rd_idx     <= '0;
         rd_valid   <= 1'b0;
      end else begin
         occ <= occ_next;
         if (accept) begin
            cand       <= occ;
            cand_count <= '0;
            scan_idx   <= '0;
         end
         if (scan_step) begin
            scan_idx <= scan_idx + 1'b1;
            if (cand[scan_idx[IW-1:0]]) cand_count <= cand_count + 1'b1;
         end
         if (sel_load) sel_q <= sel_calc;
         if (pick_load) begin
            rd_idx   <= map[sel_q];
            rd_valid <= 1'b1;
         end
         if (release_slot) rd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BS; i++) map[i] <= '0;
      end else if (scan_step && cand[scan_idx[IW-1:0]]) begin
         map[cand_count[IW-1:0]] <= scan_idx[IW-1:0];
      end
   end

endmodule

// File: tb/tb_esm_evict_scheduler.sv
// Directed bench for esm_evict_scheduler (BS=16): allocation, latency,
// concurrent events, reset abort and pick distribution.
module tb_esm_evict_scheduler;
   import esm_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_req = 1'b0, rd_req = 1'b0, rd_ack = 1'b0;
   logic        wr_gnt, rd_valid, full, empty, busy;
   logic [3:0]  wr_idx, rd_idx;
   logic [15:0] occ;
   state_t      state;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_occ  = '0;

   esm_evict_scheduler dut (
      .clk      (clk),
      .rst      (rst),
      .wr_req   (wr_req),
      .wr_gnt   (wr_gnt),
      .wr_idx   (wr_idx),
      .rd_req   (rd_req),
      .rd_valid (rd_valid),
      .rd_idx   (rd_idx),
      .rd_ack   (rd_ack),
      .occ      (occ),
      .full     (full),
      .empty    (empty),
      .busy     (busy),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lowest_free(input logic [15:0] o);
      int r;
      r = 0;
      for (int i = 15; i >= 0; i--) if (!o[i]) r = i;
      return r;
   endfunction

   function automatic int lowest_set(input logic [15:0] o);
      int r;
      r = 0;
      for (int i = 15; i >= 0; i--) if (o[i]) r = i;
      return r;
   endfunction

   task automatic do_write();
      int exp_idx;
      exp_idx = lowest_free(m_occ);
      wr_req  = 1'b1;
      #1;
      check("wr_gnt", {31'd0, wr_gnt}, 1);
      check("wr_idx", {28'd0, wr_idx}, exp_idx);
      tick();
      wr_req = 1'b0;
      m_occ[exp_idx] = 1'b1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!rd_valid && n < 40) begin
         tick();
         n++;
      end
      if (!rd_valid) check("pick_timeout", 0, 1);
   endtask

   task automatic pick(output int idx);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      wait_valid();
      idx = int'(rd_idx);
   endtask

   task automatic ack(input int idx);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      m_occ[idx] = 1'b0;
   endtask

   initial begin
      int idx, x, guard;
      int cnt [4];
      int bad;

      // Reset values
      tick();
      tick();
      check("rst_occ", {16'd0, occ}, 0);
      check("rst_rd_valid", {31'd0, rd_valid}, 0);
      check("rst_rd_idx", {28'd0, rd_idx}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_empty", {31'd0, empty}, 1);
      check("rst_state", {30'd0, state}, IDLE);
      rst = 1'b0;
      tick();

      // First three grants
      for (int i = 0; i < 3; i++) do_write();
      check("occ_3", {16'd0, occ}, 32'h0007);
      check("empty_3", {31'd0, empty}, 0);
      check("full_3", {31'd0, full}, 0);

      // Fill to full, then a refused request
      for (int i = 3; i < 16; i++) do_write();
      check("full_16", {31'd0, full}, 1);
      wr_req = 1'b1;
      #1;
      check("gnt_full", {31'd0, wr_gnt}, 0);
      check("idx_full", {28'd0, wr_idx}, 0);
      tick();
      wr_req = 1'b0;
      check("occ_full_hold", {16'd0, occ}, 32'hFFFF);

      // Ack and refused write in the same cycle
      pick(idx);
      check("sim_valid", {31'd0, rd_valid}, 1);
      wr_req = 1'b1;
      rd_ack = 1'b1;
      #1;
      check("sim_gnt", {31'd0, wr_gnt}, 0);
      tick();
      wr_req = 1'b0;
      rd_ack = 1'b0;
      m_occ[idx] = 1'b0;
      check("sim_occ", {16'd0, occ}, {16'd0, m_occ});
      check("sim_full", {31'd0, full}, 0);
      check("sim_state", {30'd0, state}, IDLE);
      check("sim_rd_valid", {31'd0, rd_valid}, 0);

      // Stray ack in IDLE is ignored
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("stray_ack_occ", {16'd0, occ}, {16'd0, m_occ});

      // Drain: every pick must be a currently occupied slot
      guard = 0;
      while (m_occ != 16'd0 && guard < 20) begin
         guard++;
`ifdef ESM_FIXED_PRIO_EN
         x = lowest_set(m_occ);
         pick(idx);
         check("drain_fixed", idx, x);
`else
         pick(idx);
`endif
         check("drain_occupied", {31'd0, m_occ[idx]}, 1);
         ack(idx);
         check("drain_occ", {16'd0, occ}, {16'd0, m_occ});
      end
      check("drain_empty", {31'd0, empty}, 1);

      // Request while empty is not accepted
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check("empty_req_busy", {31'd0, busy}, 0);

      // Latency: accept at edge N, rd_valid after edge N+18
      do_write();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check("lat_busy", {31'd0, busy}, 1);
      for (int k = 1; k < 18; k++) tick();
      check("lat_early", {31'd0, rd_valid}, 0);
      tick();
      check("lat_valid", {31'd0, rd_valid}, 1);
      check("lat_idx", {28'd0, rd_idx}, 0);
      ack(0);
      check("lat_occ", {16'd0, occ}, 0);
      check("lat_empty", {31'd0, empty}, 1);
      check("lat_state", {30'd0, state}, IDLE);

      // Write landing during SCAN is not a candidate
      for (int i = 0; i < 3; i++) do_write();
      pick(x);
      ack(x);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      tick();
      check("scan_state", {30'd0, state}, SCAN);
      do_write();
      check("scan_occ_set", {31'd0, occ[x]}, 1);
      wait_valid();
      idx = int'(rd_idx);
      check("scan_not_new", {31'd0, (idx != x)}, 1);
      check("scan_pick_occ", {31'd0, m_occ[idx]}, 1);

      // Reset asserted in PRESENT
      check("pre_rst_state", {30'd0, state}, PRESENT);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", {31'd0, rd_valid}, 0);
      check("rst_mid_occ", {16'd0, occ}, 0);
      check("rst_mid_busy", {31'd0, busy}, 0);
      tick();
      rst    = 1'b0;
      m_occ  = '0;
      tick();

      // Distribution over four occupied slots
      for (int i = 0; i < 4; i++) do_write();
      check("dist_occ", {16'd0, occ}, 32'h000F);
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      bad = 0;
      for (int n = 0; n < 3000; n++) begin
         pick(idx);
         if (idx < 4) cnt[idx]++;
         else bad++;
         ack(idx);
         do_write();
      end
      check("dist_other", bad, 0);
`ifdef ESM_FIXED_PRIO_EN
      check("dist_fixed_0", cnt[0], 3000);
`else
      for (int i = 0; i < 4; i++)
         check($sformatf("dist_slot%0d", i), {31'd0, (cnt[i] >= 630 && cnt[i] <= 870)}, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
